exact_mult_slot_server: RTL
===========================

Name: exact_mult_slot_server

Overview:
- Shared exact-multiplier server for one PE triplet; the responder side of the PE exact-multiplier slot protocol.
- Generates the 3-phase slot counter on fast_clk (counter_for_exact_mult_usage).
- Accepts high-half multiply requests (aH, bH) from three PEs and serves each PE only in its own slot, using one time-multiplexed exact multiplier.
- Returns the signed product per PE with a one-cycle valid pulse.

Parameters:
- HALF_WIDTH, 4, width of each signed high-half operand (DATA_WIDTH/2).
- PROD_WIDTH, 8, product width; must equal 2*HALF_WIDTH.

Ports:
- fast_clk  in  1  service clock (3x PE clk, phase-aligned).
- rst  in  1  asynchronous, active-high reset.
- en  in  1  slot-advance enable; 0 freezes slot and service.
- slot  out  2  counter_for_exact_mult_usage to the PEs.
- req  in  3  per-PE request pulse, bit i = PE i.
- aH_bus  in  3*HALF_WIDTH  signed operand A, PE i at [i*HALF_WIDTH +: HALF_WIDTH].
- bH_bus  in  3*HALF_WIDTH  signed operand B, same packing.
- res_bus  out  3*PROD_WIDTH  signed product per PE, PE i at [i*PROD_WIDTH +: PROD_WIDTH].
- res_valid  out  3  one-cycle pulse per PE when res_bus slice updates.
- pending  out  3  request captured, not yet served.
- overrun  out  3  sticky; new req while already pending.

Behaviour:
- Reset (asynchronous, fast_clk domain) forces:
  - slot=0, pending=0, overrun=0, res_valid=0, res_bus=0.
  - Operand registers = 0.
- Slot sequence:
  - On each fast_clk edge with en=1: 0→1, 1→2, 2→3, 3→1.
  - 0 occurs only after reset and never recurs.
  - en=0: slot holds, no service, res_valid=0. Request capture still operates.
- Slot ownership: slot 1 = PE0, slot 2 = PE1, slot 3 = PE2, slot 0 = no owner.
- Request capture (per PE i, every edge, independent of en):
  - req[i]=1 loads aH_i/bH_i into PE i operand registers and sets pending[i].
  - If pending[i] was already 1 and not being served on this edge: operands are overwritten (latest wins) and overrun[i] is set. overrun clears only on rst.
- Service, at an edge with en=1 and current slot value S=k≠0, owner i=k-1, when pending[i]=1 or req[i]=1:
  - Operands used are the bus values if req[i]=1 on this edge, else the registered values.
  - Product = signed(aH)*signed(bH), full PROD_WIDTH, exact, no saturation.
  - Registered into res_bus slice i.
  - res_valid[i]=1 for exactly the following cycle; pending[i] clears.
  - req and pending together on the serving edge: served once with the bus operands; no overrun.
- Non-owner PEs are never served in another PE's slot; their pending bits persist.
- At most one res_valid bit is high in any cycle.
- Latency from the req edge to res_valid (en held 1):
  - 1 cycle if req lands on its own slot edge.
  - Otherwise up to 3 cycles, so the worst case is 3 fast_clk = one PE clk.
- res_bus slices hold their value until the next service of the same PE.
- Multiplier: a single shared instance, muxed by slot. One output register stage; no other pipelining.
- Reset mid-operation: all pending requests are dropped without a result; slot restarts at 0.
- Unused input combos (req for the slot-0 cycle) are captured normally and served at that PE's first owned slot.

Test Plan:
- Slot sequence: reset 2 cycles, release, en=1 → slot 0,1,2,3,1,2,3,1; en=0 for 2 cycles at slot=2 → slot holds 2, then resumes 3.
- Basic service:
  - PE0 req with aH=5, bH=-3 on the edge where slot=1 → next cycle res_valid=3'b001, PE0 res=-15, pending[0]=0.
  - PE0 res remains -15 for all following cycles with no new PE0 req.
- Deferred service: PE2 req aH=-8, bH=-8 while slot=1 → pending[2]=1 for 2 cycles; served at slot=3 edge → res=64, res_valid=3'b100.
- Triplet: all three req in one cycle with (7,7), (-8,7), (-1,-1) → PE results 49, -56, 1 in successive cycles, never two valid bits at once.
- Overrun: PE1 req (2,3) at slot=3, then req (4,4) next edge (slot=1) → overrun[1]=1; result 16 at slot 2 service; overrun stays 1 until rst.
- Reset mid-op: PE1 pending, assert rst asynchronously → pending=0, res_valid=0, res_bus=0, slot=0 immediately; after release PE1 gets no result without a new req.

Source files
------------

// File: rtl/exact_mult_slot_server.sv
// Shared exact-multiplier server for one PE triplet: drives the 3-phase slot
// counter and serves each PE's high-half multiply request only in its own slot.
module exact_mult_slot_server #(
  parameter int unsigned HALF_WIDTH = 4,
  parameter int unsigned PROD_WIDTH = 8
) (
  input  logic                      fast_clk,
  input  logic                      rst,
  input  logic                      en,
  output logic [1:0]                slot,
  input  logic [2:0]                req,
  input  logic [3*HALF_WIDTH-1:0]   aH_bus,
  input  logic [3*HALF_WIDTH-1:0]   bH_bus,
  output logic [3*PROD_WIDTH-1:0]   res_bus,
  output logic [2:0]                res_valid,
  output logic [2:0]                pending,
  output logic [2:0]                overrun
);

  localparam int unsigned NUM_PE = 3;

  logic [HALF_WIDTH-1:0]        a_reg [NUM_PE];
  logic [HALF_WIDTH-1:0]        b_reg [NUM_PE];
  logic [HALF_WIDTH-1:0]        a_cur [NUM_PE];
  logic [HALF_WIDTH-1:0]        b_cur [NUM_PE];
  logic [2:0]                   owner;
  logic                         serve;
  logic signed [HALF_WIDTH-1:0] op_a;
  logic signed [HALF_WIDTH-1:0] op_b;
  logic signed [PROD_WIDTH-1:0] prod;

  // A request on the serving edge bypasses the operand registers.
  always_comb begin
    for (int i = 0; i < NUM_PE; i++) begin
      a_cur[i] = req[i] ? aH_bus[i*HALF_WIDTH +: HALF_WIDTH] : a_reg[i];
      b_cur[i] = req[i] ? bH_bus[i*HALF_WIDTH +: HALF_WIDTH] : b_reg[i];
    end
  end

  // Slot-owner mux feeding the single shared multiplier.
  always_comb begin
    owner = 3'b000;
    op_a  = '0;
    op_b  = '0;
    case (slot)
      2'd1: begin owner = 3'b001; op_a = a_cur[0]; op_b = b_cur[0]; end
      2'd2: begin owner = 3'b010; op_a = a_cur[1]; op_b = b_cur[1]; end
      2'd3: begin owner = 3'b100; op_a = a_cur[2]; op_b = b_cur[2]; end
      default: ;
    endcase
    serve = en && (|(owner & (pending | req)));
    prod  = PROD_WIDTH'(op_a) * PROD_WIDTH'(op_b);
  end

  always_ff @(posedge fast_clk or posedge rst) begin
    if (rst) begin
      slot      <= 2'd0;
      res_bus   <= '0;
      res_valid <= 3'b000;
      pending   <= 3'b000;
      overrun   <= 3'b000;
      for (int i = 0; i < NUM_PE; i++) begin
        a_reg[i] <= '0;
        b_reg[i] <= '0;
      end
    end else begin
      // Slot 0 is only the post-reset phase; the cycle is 1,2,3.
      if (en) slot <= (slot == 2'd3) ? 2'd1 : slot + 2'd1;
      res_valid <= serve ? owner : 3'b000;
      for (int i = 0; i < NUM_PE; i++) begin
        if (req[i]) begin
          a_reg[i] <= aH_bus[i*HALF_WIDTH +: HALF_WIDTH];
          b_reg[i] <= bH_bus[i*HALF_WIDTH +: HALF_WIDTH];
        end
        if (serve && owner[i]) begin
          pending[i]                        <= 1'b0;
          res_bus[i*PROD_WIDTH +: PROD_WIDTH] <= prod;
        end else if (req[i]) begin
          pending[i] <= 1'b1;
          if (pending[i]) overrun[i] <= 1'b1;
        end
      end
    end
  end

endmodule
